bit_serial_alu_ctrl: RTL

- Sequencer that runs WIDTH-bit ALU operations through a single 1-bit ALU slice, one bit per clock, LSB first.
- Holds the operand and result shift registers, the carry flop, the bit counter and the op decode (sel/binvert/less) for the slice.
- Sits between the CPU-side issue logic (start/ready handshake) and the shared 1-bit slice; trades area for latency.

---
 rtl/bsalu_pkg.sv | 43 ++++
 rtl/alu_bit_slice.sv | 33 +++
 rtl/bit_serial_alu_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bsalu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: op codes, slice select codes,
// controller states and the op decode helper.
package bsalu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_LESS = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } bsalu_state_e;

    typedef struct packed {
        logic [1:0] sel;
        logic       binvert;
        logic       arith;
        logic       slt;
    } bsalu_ctl_t;

    // Unlisted op codes fall back to ADD.
    function automatic bsalu_ctl_t bsalu_decode(input logic [2:0] op);
        bsalu_ctl_t ctl;
        case (op)
            OP_AND:  ctl = '{sel: SEL_AND,  binvert: 1'b0, arith: 1'b0, slt: 1'b0};
            OP_OR:   ctl = '{sel: SEL_OR,   binvert: 1'b0, arith: 1'b0, slt: 1'b0};
            OP_SUB:  ctl = '{sel: SEL_ADD,  binvert: 1'b1, arith: 1'b1, slt: 1'b0};
            OP_SLT:  ctl = '{sel: SEL_LESS, binvert: 1'b1, arith: 1'b1, slt: 1'b1};
            default: ctl = '{sel: SEL_ADD,  binvert: 1'b0, arith: 1'b1, slt: 1'b0};
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: AND / OR / full-add / less, with optional B inversion.
module alu_bit_slice
    import bsalu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       binvert_i,
    input  logic       less_i,
    input  logic [1:0] sel_i,
    output logic       res_o,
    output logic       sum_o,
    output logic       cout_o
);

    logic b_eff;

    assign b_eff  = b_i ^ binvert_i;
    assign sum_o  = a_i ^ b_eff ^ cin_i;
    assign cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));

    always_comb begin
        res_o = 1'b0;
        unique case (sel_i)
            SEL_AND:  res_o = a_i & b_eff;
            SEL_OR:   res_o = a_i | b_eff;
            SEL_ADD:  res_o = sum_o;
            SEL_LESS: res_o = less_i;
            default:  res_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs WIDTH-bit ops through one alu_bit_slice, LSB first.
// Optional BSALU_OVERFLOW_EN adds a registered signed-overflow output for ADD/SUB.
module bit_serial_alu_ctrl
    import bsalu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_out_o
`ifdef BSALU_OVERFLOW_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    bsalu_state_e     state_q;
    bsalu_ctl_t       ctl_q;
    bsalu_ctl_t       ctl_in;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             msb_cin_q;
    logic             sign_q;
    logic             ready_q, done_q, zero_q, carry_out_q;
`ifdef BSALU_OVERFLOW_EN
    logic             ovf_q;
`endif

    logic             slice_res, slice_sum, slice_cout;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;
    logic             slt_set;

    assign ctl_in    = bsalu_decode(op_i);
    assign res_shift = {slice_res, res_q[WIDTH-1:1]};
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    // In FIX, carry_q holds the carry out of the MSB.
    assign slt_set   = sign_q ^ (msb_cin_q ^ carry_q);

    alu_bit_slice u_slice (
        .a_i       (a_q[0]),
        .b_i       (b_q[0]),
        .cin_i     (carry_q),
        .binvert_i (ctl_q.binvert),
        .less_i    (1'b0),
        .sel_i     (ctl_q.sel),
        .res_o     (slice_res),
        .sum_o     (slice_sum),
        .cout_o    (slice_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ctl_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            msb_cin_q   <= 1'b0;
            sign_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            zero_q      <= 1'b1;
            carry_out_q <= 1'b0;
`ifdef BSALU_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        ctl_q   <= ctl_in;
                        carry_q <= ctl_in.binvert;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    res_q   <= res_shift;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        msb_cin_q <= carry_q;
                        sign_q    <= slice_sum;
                        if (ctl_q.slt) begin
                            state_q <= StFix;
                        end else begin
                            state_q     <= StDone;
                            done_q      <= 1'b1;
                            zero_q      <= (res_shift == '0);
                            carry_out_q <= ctl_q.arith & slice_cout;
`ifdef BSALU_OVERFLOW_EN
                            ovf_q       <= ctl_q.arith & (carry_q ^ slice_cout);
`endif
                        end
                    end
                end
                StFix: begin
                    res_q       <= {{(WIDTH-1){1'b0}}, slt_set};
                    zero_q      <= ~slt_set;
                    carry_out_q <= carry_q;
`ifdef BSALU_OVERFLOW_EN
                    ovf_q       <= 1'b0;
`endif
                    done_q      <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign result_o    = res_q;
    assign zero_o      = zero_q;
    assign carry_out_o = carry_out_q;
`ifdef BSALU_OVERFLOW_EN
    assign overflow_o  = ovf_q;
`endif

endmodule
